button_input_ctrl: RTL and testbench



---
 rtl/gdsp_io_pkg.sv | 29 ++
 rtl/btn_channel.sv | 142 ++++++++++++++
 rtl/button_input_ctrl.sv | 59 +++++
 tb/tb_button_input_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gdsp_io_pkg.sv
// ---------------------------------------------------------------------------
// gdsp_io_pkg
// Shared constants and types for the board I/O blocks (LED status outputs,
// push-button inputs). All timing constants are expressed in clk_27m cycles
// and derived from millisecond figures so that they stay readable.
// ---------------------------------------------------------------------------
package gdsp_io_pkg;

  localparam int unsigned CLK_27M_HZ    = 27_000_000;
  localparam int unsigned CYC_PER_MS    = CLK_27M_HZ / 1000;

  // Debounce window and long-press threshold, in milliseconds
  localparam int unsigned DEBOUNCE_MS   = 10;
  localparam int unsigned LONG_PRESS_MS = 1000;

  localparam int unsigned DEBOUNCE_CYC_DEF = CYC_PER_MS * DEBOUNCE_MS;
  localparam int unsigned LONG_CYC_DEF     = CYC_PER_MS * LONG_PRESS_MS;

  // The Tang Nano carries two user push-buttons
  localparam int unsigned N_BTN_BOARD = 2;

  // Per-button press classification state
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

endpackage

// File: rtl/btn_channel.sv
// ---------------------------------------------------------------------------
// btn_channel
// One push-button channel: 2-FF synchroniser, debounce filter, hold-time
// counter and a press-classification FSM (IDLE / PRESSED / LONG).
//
// Ports:
//   clk_27m        in   system clock
//   rst_n          in   asynchronous active-low reset
//   btn_n          in   raw button pin, active-low, asynchronous
//   btn_level      out  debounced level, active-high
//   press_pulse    out  1-cycle strobe in the first cycle btn_level is 1
//   release_pulse  out  1-cycle strobe in the first cycle btn_level is 0
//   short_pulse    out  1-cycle strobe on release of a press shorter than LONG_CYC
//   long_pulse     out  1-cycle strobe when the hold time reaches LONG_CYC
//   long_held      out  high from long_pulse until the accepted release
// ---------------------------------------------------------------------------
module btn_channel
  import gdsp_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned LONG_CYC     = LONG_CYC_DEF
) (
  input  logic clk_27m,
  input  logic rst_n,
  input  logic btn_n,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic long_held
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYC);
  localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [1:0]        sync_q;
  logic              raw_p;
  logic [DEB_W-1:0]  deb_cnt_q;
  logic              level_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  btn_state_t        state_q, state_d;

  // Two-flop synchroniser; flops reset to 1 so a reset looks like "released"
  always_ff @(posedge clk_27m or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btn_n};
    end
  end

  assign raw_p = ~sync_q[1];

  // Debounce: the level only follows raw_p after DEBOUNCE_CYC consecutive
  // differing cycles; any agreeing cycle restarts the count
  always_ff @(posedge clk_27m or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
    end else if (raw_p == level_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      level_q   <= raw_p;
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_q + DEB_W'(1);
    end
  end

  assign btn_level = level_q;

  // FSM state and hold counter registers
  always_ff @(posedge clk_27m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Strobes are decoded from the registered state and level, so each fires
  // exactly in the first cycle the debounced level has its new value
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    press_pulse   = 1'b0;
    release_pulse = 1'b0;
    short_pulse   = 1'b0;
    long_pulse    = 1'b0;
    long_held     = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q) begin
          press_pulse = 1'b1;
          state_d     = PRESSED;
          hold_d      = HOLD_ONE;
        end
      end
      PRESSED: begin
        if (!level_q) begin
          release_pulse = 1'b1;
          short_pulse   = 1'b1;
          state_d       = IDLE;
          hold_d        = '0;
        end else if (hold_q == HOLD_LAST) begin
          long_pulse = 1'b1;
          long_held  = 1'b1;
          state_d    = LONG;
          hold_d     = hold_q + HOLD_ONE;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      LONG: begin
        if (!level_q) begin
          release_pulse = 1'b1;
          state_d       = IDLE;
          hold_d        = '0;
        end else begin
          long_held = 1'b1;
          // Saturate so an endless hold never wraps back below the threshold
          if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_input_ctrl.sv
// ---------------------------------------------------------------------------
// button_input_ctrl
// Reads the raw active-low board push-buttons in the clk_27m domain and
// turns each into a clean level plus press/release/short/long strobes.
// Channels are fully independent; there is no arbitration between them.
//
// Ports:
//   clk_27m        in   system clock, 27 MHz
//   rst_n          in   asynchronous active-low reset
//   btn_n          in   [N_BTN] raw button pins, active-low, asynchronous
//   btn_level      out  [N_BTN] debounced state, active-high
//   press_pulse    out  [N_BTN] strobe on accepted press
//   release_pulse  out  [N_BTN] strobe on accepted release
//   short_pulse    out  [N_BTN] strobe on release of a short press
//   long_pulse     out  [N_BTN] strobe when hold time reaches LONG_CYC
//   long_held      out  [N_BTN] high from long_pulse until release
// ---------------------------------------------------------------------------
module button_input_ctrl
  import gdsp_io_pkg::*;
#(
  parameter int unsigned N_BTN        = N_BTN_BOARD,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned LONG_CYC     = LONG_CYC_DEF
) (
  input  logic             clk_27m,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] short_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] long_held
);

  // The debounce counter needs at least one bit and the long threshold must
  // lie beyond the debounce window, otherwise classification is meaningless
  if (DEBOUNCE_CYC < 2 || LONG_CYC <= DEBOUNCE_CYC) begin : g_param_check
    $error("button_input_ctrl: need DEBOUNCE_CYC >= 2 and LONG_CYC > DEBOUNCE_CYC");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC)
    ) u_ch (
      .clk_27m       (clk_27m),
      .rst_n         (rst_n),
      .btn_n         (btn_n[i]),
      .btn_level     (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .short_pulse   (short_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .long_held     (long_held[i])
    );
  end

endmodule

// File: tb/tb_button_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_button_input_ctrl
// Self-checking bench for button_input_ctrl with short timing constants.
// A behavioural reference model (sliding window of synchronised samples plus
// press-age arithmetic) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_button_input_ctrl;

  localparam int N = 2;
  localparam int D = 8;
  localparam int L = 64;

  logic         clk_27m = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_n;
  logic [N-1:0] btn_level, press_pulse, release_pulse, short_pulse, long_pulse, long_held;

  always #5 clk_27m = ~clk_27m;

  button_input_ctrl #(
    .N_BTN        (N),
    .DEBOUNCE_CYC (D),
    .LONG_CYC     (L)
  ) dut (
    .clk_27m       (clk_27m),
    .rst_n         (rst_n),
    .btn_n         (btn_n),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_pulse   (short_pulse),
    .long_pulse    (long_pulse),
    .long_held     (long_held)
  );

  int checks   = 0;
  int failures = 0;
  int stepIdx  = 0;
  int obsIdx   = 0;

  // Reference model state
  bit [N-1:0] h1, h2;
  bit [N-1:0] win[$];
  bit [N-1:0] mLevel, ePress, eRel, eShort, eLong, eHeld;
  int         pressAt[N];
  int         mCycle;

  // Last observed DUT outputs and pulse tallies
  logic [N-1:0] oLevel, oPress, oRel, oShort, oLong, oHeld;
  int cntP[N], cntR[N], cntS[N], cntL[N];
  int activity;

  logic [11:0] dutVec, modelVec;
  assign dutVec   = {btn_level, press_pulse, release_pulse, short_pulse, long_pulse, long_held};
  assign modelVec = {mLevel, ePress, eRel, eShort, eLong, eHeld};

  typedef struct {
    string       name;
    logic [1:0]  btn;
    int          cyc;
    logic [31:0] expCnt;   // {press, release, short, long}, each {ch1 nibble, ch0 nibble}
    logic [1:0]  endLevel;
    logic [1:0]  endHeld;
  } vec_t;

  vec_t tbl[11];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (step %0d)", name, act, exp, obsIdx);
    end
  endtask

  task automatic modelReset();
    h1 = '1;
    h2 = '1;
    win.delete();
    mLevel = '0; ePress = '0; eRel = '0; eShort = '0; eLong = '0; eHeld = '0;
    for (int i = 0; i < N; i++) pressAt[i] = 0;
    mCycle = 0;
  endtask

  // One clock edge of the reference: the pin value seen by the filter is the
  // one applied two edges earlier; a new level is accepted once the last D
  // filter samples all agree with it. Pulses follow from the press age.
  task automatic modelEdge(input logic [N-1:0] b);
    bit [N-1:0] r, newL;
    bit         same;
    int         age;
    r  = ~h2;
    h2 = h1;
    h1 = b;
    mCycle++;
    win.push_back(r);
    if (win.size() > D) void'(win.pop_front());
    newL = mLevel;
    if (win.size() == D) begin
      for (int i = 0; i < N; i++) begin
        same = 1'b1;
        foreach (win[j]) if (win[j][i] != r[i]) same = 1'b0;
        if (same && r[i] != mLevel[i]) newL[i] = r[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      ePress[i] = newL[i] & ~mLevel[i];
      eRel[i]   = ~newL[i] & mLevel[i];
      if (ePress[i]) pressAt[i] = mCycle;
      age       = mCycle - pressAt[i];
      eLong[i]  = newL[i] && (age == L - 1);
      eHeld[i]  = newL[i] && (age >= L - 1);
      eShort[i] = eRel[i] && (age <= L - 1);
    end
    mLevel = newL;
  endtask

  task automatic clearCounts();
    for (int i = 0; i < N; i++) begin
      cntP[i] = 0; cntR[i] = 0; cntS[i] = 0; cntL[i] = 0;
    end
    activity = 0;
  endtask

  // Observe and check the outputs of the finished cycle, then drive the
  // next pin value and advance the model by the edge that will sample it
  task automatic applyStimulus(input logic [N-1:0] b);
    @(negedge clk_27m);
    obsIdx = stepIdx;
    oLevel = btn_level; oPress = press_pulse; oRel = release_pulse;
    oShort = short_pulse; oLong = long_pulse; oHeld = long_held;
    checkOutput("cycle", int'(dutVec), int'(modelVec));
    for (int i = 0; i < N; i++) begin
      cntP[i] += int'(oPress[i]);
      cntR[i] += int'(oRel[i]);
      cntS[i] += int'(oShort[i]);
      cntL[i] += int'(oLong[i]);
    end
    if (dutVec != 12'd0) activity++;
    btn_n = b;
    modelEdge(b);
    stepIdx++;
  endtask

  task automatic releaseReset(input logic [N-1:0] b);
    @(negedge clk_27m);
    rst_n = 1'b1;
    modelReset();
    btn_n = b;
    modelEdge(b);
    stepIdx++;
  endtask

  function automatic logic [31:0] packCounts();
    logic [31:0] v;
    v = {cntP[1][3:0], cntP[0][3:0], cntR[1][3:0], cntR[0][3:0],
         cntS[1][3:0], cntS[0][3:0], cntL[1][3:0], cntL[0][3:0]};
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, pIdx, lIdx, r0;
    logic [N-1:0] pVal, lVal;
    logic [N-1:0] cur;
    int rem[N];
    bit found;

    tbl[0]  = '{"idle",           2'b11, 200, 32'h00_00_00_00, 2'b00, 2'b00};
    tbl[1]  = '{"press0_short",   2'b10,  30, 32'h01_00_00_00, 2'b01, 2'b00};
    tbl[2]  = '{"release0_short", 2'b11,  40, 32'h00_01_01_00, 2'b00, 2'b00};
    tbl[3]  = '{"hold1_long",     2'b01, 200, 32'h10_00_00_10, 2'b10, 2'b10};
    tbl[4]  = '{"release1_long",  2'b11,  40, 32'h00_10_00_00, 2'b00, 2'b00};
    tbl[5]  = '{"glitch7",        2'b10,   7, 32'h00_00_00_00, 2'b00, 2'b00};
    tbl[6]  = '{"after_glitch7",  2'b11,  30, 32'h00_00_00_00, 2'b00, 2'b00};
    tbl[7]  = '{"glitch8",        2'b10,   8, 32'h00_00_00_00, 2'b00, 2'b00};
    tbl[8]  = '{"after_glitch8",  2'b11,  30, 32'h01_01_01_00, 2'b00, 2'b00};
    tbl[9]  = '{"both_long",      2'b00, 100, 32'h11_00_00_11, 2'b11, 2'b11};
    tbl[10] = '{"both_release",   2'b11,  40, 32'h00_11_00_00, 2'b00, 2'b00};

    rst_n = 1'b0;
    btn_n = 2'b11;
    modelReset();
    clearCounts();
    repeat (3) @(posedge clk_27m);
    @(negedge clk_27m);
    checkOutput("reset_state", int'(dutVec), 0);
    releaseReset(2'b11);

    // Table-driven scenarios
    foreach (tbl[k]) begin
      clearCounts();
      for (int n = 0; n < tbl[k].cyc; n++) applyStimulus(tbl[k].btn);
      checkOutput({tbl[k].name, "_counts"}, int'(packCounts()), int'(tbl[k].expCnt));
      checkOutput({tbl[k].name, "_end"}, int'({oLevel, oHeld}), int'({tbl[k].endLevel, tbl[k].endHeld}));
    end

    // Bounce: toggle every 3 cycles, nothing may ever reach the outputs
    clearCounts();
    for (int n = 0; n < 40; n++) applyStimulus({1'b1, 1'(((n / 3) % 2) != 0)});
    for (int n = 0; n < 30; n++) applyStimulus(2'b11);
    checkOutput("bounce_activity", activity, 0);

    // Simultaneous press, then independent long timing on channel 0
    clearCounts();
    t0 = stepIdx; pIdx = -1000; pVal = '0; found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      applyStimulus(2'b00);
      if (oPress != '0) begin found = 1'b1; pIdx = obsIdx; pVal = oPress; end
    end
    checkOutput("sim_press_value", int'(pVal), 3);
    checkOutput("sim_press_latency", pIdx - t0, D + 2);
    lIdx = -1000; lVal = '0; found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      applyStimulus(2'b10);
      if (oLong != '0) begin found = 1'b1; lIdx = obsIdx; lVal = oLong; end
    end
    checkOutput("sim_long_value", int'(lVal), 1);
    checkOutput("sim_long_latency", lIdx - pIdx, L - 1);
    for (int n = 0; n < 40; n++) applyStimulus(2'b11);
    checkOutput("sim_ch1_short", cntS[1], 1);
    checkOutput("sim_ch1_long", cntL[1], 0);
    checkOutput("sim_ch0_short", cntS[0], 0);

    // Reset while channel 0 is in its long-held phase
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      applyStimulus(2'b10);
      if (oHeld[0]) found = 1'b1;
    end
    checkOutput("long_reached", int'(found), 1);
    repeat (5) applyStimulus(2'b10);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_clear", int'(dutVec), 0);
    repeat (3) @(posedge clk_27m);
    clearCounts();
    r0 = stepIdx;
    releaseReset(2'b10);
    pIdx = -1000; found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      applyStimulus(2'b10);
      if (oPress[0]) begin found = 1'b1; pIdx = obsIdx; end
    end
    checkOutput("rst_press_latency", pIdx - r0, D + 2);
    lIdx = -1000; found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      applyStimulus(2'b10);
      if (oLong[0]) begin found = 1'b1; lIdx = obsIdx; end
    end
    checkOutput("rst_long_latency", lIdx - pIdx, L - 1);
    for (int n = 0; n < 40; n++) applyStimulus(2'b11);
    checkOutput("rst_release_count", cntR[0], 1);
    checkOutput("rst_short_count", cntS[0], 0);

    // Randomised mix of glitches and holds, checked cycle by cycle
    cur = 2'b11;
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          cur[i] = ~cur[i];
          rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 140))
                                               : int'($urandom_range(1, 12));
        end
        rem[i]--;
      end
      applyStimulus(cur);
    end
    for (int n = 0; n < 100; n++) applyStimulus(2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
